// File: rtl/seq_arith_pkg.sv
// Shared types and sizing helpers for the sequential arithmetic blocks
// (divider, and the shift-add multiplier that sits beside it).
package seq_arith_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CT_WIDTH      = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter width for an arbitrary operand width.
    function automatic int ct_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] pr_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dv_i,
    output logic [WIDTH-1:0] pr_o,
    output logic             q_o
);

    logic [WIDTH:0] t_s;

    assign t_s = {pr_i, bit_i};

    // The difference is always below the divisor, so it fits in WIDTH bits
    // and a modulo-2^WIDTH subtract gives the exact value.
    always_comb begin
        pr_o = t_s[WIDTH-1:0];
        q_o  = 1'b0;
        if (t_s >= {1'b0, dv_i}) begin
            pr_o = t_s[WIDTH-1:0] - dv_i;
            q_o  = 1'b1;
        end else begin
            pr_o = t_s[WIDTH-1:0];
            q_o  = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// WIDTH iterations per job, START/READY handshake, overflow flag.
module seq_divider
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 START,
    input  logic [2*WIDTH-1:0]   N,
    input  logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     R,
    output logic                 READY,
    output logic                 OVF
);

    localparam int CT_W = ct_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic [WIDTH-1:0] nl_q, nl_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic [CT_W-1:0]  ct_q, ct_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ready_q, ready_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] step_pr_s;
    logic             step_q_s;
    logic [WIDTH-1:0] nl_shift_s;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .pr_i  (pr_q),
        .bit_i (nl_q[WIDTH-1]),
        .dv_i  (dv_q),
        .pr_o  (step_pr_s),
        .q_o   (step_q_s)
    );

    assign nl_shift_s = {nl_q[WIDTH-2:0], step_q_s};

    // Next-state, datapath and output logic; START restarts from any state.
    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        nl_d    = nl_q;
        dv_d    = dv_q;
        ct_d    = ct_q;
        q_d     = q_q;
        r_d     = r_q;
        ready_d = ready_q;
        ovf_d   = ovf_q;
        if (START) begin
            pr_d    = N[2*WIDTH-1:WIDTH];
            nl_d    = N[WIDTH-1:0];
            dv_d    = D;
            ct_d    = {CT_W{1'b0}};
            ready_d = 1'b0;
            // A high half not below the divisor would need more than WIDTH
            // quotient bits; this also catches a zero divisor.
            if (N[2*WIDTH-1:WIDTH] >= D) begin
                state_d = DONE;
                ovf_d   = 1'b1;
                q_d     = {WIDTH{1'b1}};
                r_d     = {WIDTH{1'b0}};
                ready_d = 1'b1;
            end else begin
                state_d = RUN;
                ovf_d   = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    pr_d = step_pr_s;
                    nl_d = nl_shift_s;
                    ct_d = ct_q + CT_W'(1);
                    if (ct_q == CT_W'(WIDTH - 1)) begin
                        q_d     = nl_shift_s;
                        r_d     = step_pr_s;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pr_q    <= {WIDTH{1'b0}};
            nl_q    <= {WIDTH{1'b0}};
            dv_q    <= {WIDTH{1'b0}};
            ct_q    <= {CT_W{1'b0}};
            q_q     <= {WIDTH{1'b0}};
            r_q     <= {WIDTH{1'b0}};
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            nl_q    <= nl_d;
            dv_q    <= dv_d;
            ct_q    <= ct_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q     = q_q;
    assign R     = r_q;
    assign READY = ready_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized
// jobs compared against plain integer division.
module tb_seq_divider;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           START = 1'b0;
    logic [2*W-1:0] N = '0;
    logic [W-1:0]   D = '0;
    logic [W-1:0]   Q;
    logic [W-1:0]   R;
    logic           READY;
    logic           OVF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .START (START),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .R     (R),
        .READY (READY),
        .OVF   (OVF)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load edge, then scramble the operand inputs.
    task automatic load(input logic [2*W-1:0] n, input logic [W-1:0] d);
        START = 1'b1;
        N = n;
        D = d;
        tick();
        START = 1'b0;
        N = 8'($urandom);
        D = 4'($urandom);
    endtask

    // Reference: plain integer division with the overflow rule.
    task automatic model(input logic [2*W-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic ovf);
        int ni;
        int di;
        ni = int'(n);
        di = int'(d);
        if ((ni / 16) >= di) begin
            ovf = 1'b1;
            q = 4'hF;
            r = 4'h0;
        end else begin
            ovf = 1'b0;
            q = 4'(ni / di);
            r = 4'(ni % di);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({Q, R, READY, OVF} !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold: got Q=%h R=%h READY=%b OVF=%b expected all 0", Q, R, READY, OVF);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({Q, R, READY, OVF} !== 10'b0) begin
                errors++;
                $display("FAIL idle_after_reset: got Q=%h R=%h READY=%b OVF=%b expected all 0", Q, R, READY, OVF);
            end
        end
    endtask

    task automatic test_basic();
        load(8'h64, 4'h7);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (READY !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy: got READY=%b expected 0 at edge %0d", READY, i + 2);
            end
        end
        tick();
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (READY !== 1'b1 || Q !== 4'hE || R !== 4'h2 || OVF !== 1'b0) begin
                errors++;
                $display("FAIL basic_result: got READY=%b Q=%h R=%h OVF=%b expected 1 e 2 0 (hold cycle %0d)", READY, Q, R, OVF, i);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        load(8'h2D, 4'h5);
        repeat (4) tick();
        checks++;
        if (READY !== 1'b1 || Q !== 4'h9 || R !== 4'h0 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got READY=%b Q=%h R=%h OVF=%b expected 1 9 0 0", READY, Q, R, OVF);
        end
        load(8'hEF, 4'hF);
        checks++;
        if (READY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_drop: got READY=%b expected 0", READY);
        end
        repeat (3) tick();
        checks++;
        if (READY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: got READY=%b expected 0", READY);
        end
        tick();
        checks++;
        if (READY !== 1'b1 || Q !== 4'hF || R !== 4'hE || OVF !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got READY=%b Q=%h R=%h OVF=%b expected 1 f e 0", READY, Q, R, OVF);
        end
    endtask

    task automatic test_overflow();
        logic [2*W-1:0] ns [2];
        logic [W-1:0]   ds [2];
        ns[0] = 8'h50; ds[0] = 4'h5;
        ns[1] = 8'h12; ds[1] = 4'h0;
        for (int i = 0; i < 2; i++) begin
            load(ns[i], ds[i]);
            checks++;
            if (READY !== 1'b1 || OVF !== 1'b1 || Q !== 4'hF || R !== 4'h0) begin
                errors++;
                $display("FAIL overflow_%0d: got READY=%b OVF=%b Q=%h R=%h expected 1 1 f 0", i, READY, OVF, Q, R);
            end
            tick();
        end
    endtask

    task automatic test_restart();
        int pulses;
        pulses = 0;
        load(8'h64, 4'h7);
        tick();
        if (READY === 1'b1) pulses++;
        load(8'h2D, 4'h5);
        if (READY === 1'b1) pulses++;
        repeat (3) begin
            tick();
            if (READY === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL restart_no_pulse: got %0d READY-high samples expected 0", pulses);
        end
        tick();
        checks++;
        if (READY !== 1'b1 || Q !== 4'h9 || R !== 4'h0 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL restart_result: got READY=%b Q=%h R=%h OVF=%b expected 1 9 0 0", READY, Q, R, OVF);
        end
    endtask

    task automatic test_reset_mid_run();
        load(8'h64, 4'h7);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({Q, R, READY, OVF} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got Q=%h R=%h READY=%b OVF=%b expected all 0", Q, R, READY, OVF);
        end
        repeat (5) tick();
        checks++;
        if ({Q, R, READY, OVF} !== 10'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: got Q=%h R=%h READY=%b OVF=%b expected all 0", Q, R, READY, OVF);
        end
        load(8'h64, 4'h7);
        repeat (4) tick();
        checks++;
        if (READY !== 1'b1 || Q !== 4'hE || R !== 4'h2 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_job: got READY=%b Q=%h R=%h OVF=%b expected 1 e 2 0", READY, Q, R, OVF);
        end
    endtask

    task automatic test_start_held();
        START = 1'b1;
        N = 8'h64;
        D = 4'h7;
        repeat (3) tick();
        START = 1'b0;
        N = 8'hFF;
        D = 4'h1;
        checks++;
        if (READY !== 1'b0) begin
            errors++;
            $display("FAIL held_ready_low: got READY=%b expected 0", READY);
        end
        repeat (3) tick();
        checks++;
        if (READY !== 1'b0) begin
            errors++;
            $display("FAIL held_early: got READY=%b expected 0", READY);
        end
        tick();
        checks++;
        if (READY !== 1'b1 || Q !== 4'hE || R !== 4'h2 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL held_result: got READY=%b Q=%h R=%h OVF=%b expected 1 e 2 0", READY, Q, R, OVF);
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] n;
        logic [W-1:0]   d;
        logic [W-1:0]   eq;
        logic [W-1:0]   er;
        logic           eovf;
        int             lat;
        for (int it = 0; it < 60; it++) begin
            d = 4'($urandom);
            n = 8'($urandom);
            if ((it % 3) != 0 && d != 4'h0) begin
                n[7:4] = 4'($urandom_range(0, int'(d) - 1));
            end
            model(n, d, eq, er, eovf);
            load(n, d);
            lat = 1;
            while (READY !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            checks++;
            if (lat != (eovf ? 1 : 5)) begin
                errors++;
                $display("FAIL rand_latency: N=%h D=%h got %0d edges expected %0d", n, d, lat, eovf ? 1 : 5);
            end
            checks++;
            if (READY !== 1'b1 || Q !== eq || R !== er || OVF !== eovf) begin
                errors++;
                $display("FAIL rand_result: N=%h D=%h got Q=%h R=%h OVF=%b expected Q=%h R=%h OVF=%b", n, d, Q, R, OVF, eq, er, eovf);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_reset_mid_run();
        test_start_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse of the 4x4 shift-add multiplier datapath.
- Takes a 2*WIDTH-bit dividend and a WIDTH-bit divisor on START.
- Produces a WIDTH-bit quotient and a WIDTH-bit remainder after WIDTH iteration cycles, then raises READY.
- Sits beside the multiplier in the arithmetic test suite and shares its START/READY handshake style.

Parameters:
- WIDTH, 4, divisor, quotient and remainder width; dividend is 2*WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the clk rising edge.
- START  in  1  load operands and begin division; sampled each edge.
- N  in  2*WIDTH  dividend, captured on the load edge only.
- D  in  WIDTH  divisor, captured on the load edge only.
- Q  out  WIDTH  quotient, registered.
- R  out  WIDTH  remainder, registered.
- READY  out  1  result valid; registered.
- OVF  out  1  overflow or divide-by-zero flag for the current result; registered.

Behaviour:
- Reset (reset=1 at an edge) forces state IDLE, Q=0, R=0, READY=0, OVF=0, and clears the iteration counter and working registers.
- reset has priority over START.
- States:
  - IDLE: wait for START.
  - RUN: iterate.
  - DONE: READY=1, hold results.
- Load edge: any edge with START=1, in any state, including RUN and DONE, so START restarts the divider.
  - Captures N into remainder working register PR (high half, WIDTH bits) and shift register NL (low half).
  - Captures D into DV.
  - Clears the counter CT to 0 and sets READY=0.
- Overflow check on the load edge: if N[2*WIDTH-1:WIDTH] >= D (this covers D=0):
  - Go directly to DONE with OVF=1, Q=all ones, R=0.
  - READY=1 after the load edge (latency 1).
- Otherwise set OVF=0 and go to RUN. Q and R keep their previous values throughout RUN.
- Each RUN edge with START=0:
  - T = {PR, NL msb}, WIDTH+1 bits.
  - If T >= DV: PR <= T - DV and quotient bit = 1. Otherwise PR <= T[WIDTH-1:0] and quotient bit = 0.
  - NL shifts left, with the quotient bit entering its lsb, so NL becomes the quotient.
  - CT increments.
- After exactly WIDTH RUN edges:
  - Q <= final NL and R <= final PR on the same edge.
  - READY=1 and state goes to DONE.
  - READY first reads 1 WIDTH+1 edges after the load edge.
- Width rule: T - DV < DV always holds, so PR never overflows WIDTH bits.
- DONE holds Q, R, READY and OVF until the next load edge or reset.
- START held high for several edges: each edge reloads, so no iteration proceeds until START falls.
  - First RUN edge is the first edge with START=0.
- N and D may change freely after the load edge without effect.
- Reset mid-RUN aborts the operation: outputs go to their reset values, with no partial result visible.

Decomposition:
- Shared package seq_arith_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - default WIDTH
  - counter width localparam $clog2(WIDTH+1)
- One combinational sub-module div_step performs a single restoring iteration.
  - Inputs: PR, incoming bit, DV.
  - Outputs: next PR, quotient bit.
- The top holds the FSM, the counter and the registers.

Test Plan:
- reset 2 cycles, then idle 3 cycles -> Q=0, R=0, READY=0, OVF=0 throughout.
- N=0x64, D=7, one-cycle START -> after 5 edges READY=1, Q=0xE, R=0x2, OVF=0; values hold in DONE for 10 cycles.
- Back-to-back operations:
  - N=0x2D, D=5 -> Q=9, R=0.
  - Then START in DONE with N=0xEF, D=0xF -> READY drops on the load edge; after 5 edges Q=0xF, R=0xE.
- Overflow and divide-by-zero:
  - N=0x50, D=5 -> READY=1 one edge after the load edge, OVF=1, Q=0xF, R=0.
  - N=0x12, D=0 -> same response.
- Restart mid-RUN: N=0x64, D=7, then 2 edges later START with N=0x2D, D=5 -> the first job is discarded; 5 edges after the second load Q=9, R=0, and READY never pulses in between.
- Reset mid-RUN: reset asserted on the 3rd RUN edge -> all outputs 0, state IDLE; a subsequent START with N=0x64, D=7 completes normally with Q=0xE, R=2.
- START held 3 cycles with N=0x64, D=7 -> READY=1 exactly 5 edges after the last START-high edge; result correct.
